// File: rtl/nco_bcd_scan_disp_if.sv
// Control and display signal bundle for nco_bcd_scan_disp.
// The DUT takes the slave side; the board top or bench takes the master side.
interface nco_bcd_scan_disp_if #(
  parameter int DIGITS    = 6,
  parameter int NCO_WIDTH = 32
);
  logic [NCO_WIDTH-1:0] i_nco_inc;
  logic                 i_run;
  logic                 i_up;
  logic                 i_clear;
  logic [DIGITS-1:0]    o_seg_enb;
  logic                 o_seg_dp;
  logic [6:0]           o_seg;
  logic                 o_tick;
  logic                 o_ovf;

  modport master (
    output i_nco_inc, i_run, i_up, i_clear,
    input  o_seg_enb, o_seg_dp, o_seg, o_tick, o_ovf
  );

  modport slave (
    input  i_nco_inc, i_run, i_up, i_clear,
    output o_seg_enb, o_seg_dp, o_seg, o_tick, o_ovf
  );
endinterface

// File: rtl/nco_bcd_scan_disp.sv
// NCO-driven DIGITS-wide BCD up/down counter, scanned onto a common-cathode 7-segment bank.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never blanked).
module nco_bcd_scan_disp #(
  parameter int DIGITS    = 6,
  parameter int NCO_WIDTH = 32,
  parameter int SCAN_DIV  = 50000,
  parameter int DP_POS    = 2
) (
  input logic              clk,
  input logic              rst_n,
  nco_bcd_scan_disp_if.slave bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam bit DP_EN = (DP_POS >= 0) && (DP_POS < DIGITS);
  localparam logic [IW-1:0] DP_SEL   = DP_EN ? IW'(DP_POS) : '0;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [NCO_WIDTH-1:0]   acc_q, acc_d;
  logic [DIGITS-1:0][3:0] cnt_q, cnt_d;
  logic                   tick_q, tick_d;
  logic                   ovf_q, ovf_d;
  logic [DW-1:0]          div_q, div_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DIGITS-1:0]      enb_q, enb_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [NCO_WIDTH:0]     sum;
  logic                   carry;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Clear outranks the tick: a carry in a clearing cycle is discarded without a pulse.
  always_comb begin
    logic c;
    sum    = {1'b0, acc_q} + {1'b0, bus.i_nco_inc};
    carry  = bus.i_run & sum[NCO_WIDTH];
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    ovf_d  = 1'b0;
    c      = 1'b1;
    if (bus.i_clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (bus.i_run) begin
      acc_d = sum[NCO_WIDTH-1:0];
      if (carry) begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (c) begin
            if (bus.i_up) begin
              if (cnt_q[i] == 4'd9) cnt_d[i] = 4'd0;
              else begin
                cnt_d[i] = cnt_q[i] + 4'd1;
                c        = 1'b0;
              end
            end else begin
              if (cnt_q[i] == 4'd0) cnt_d[i] = 4'd9;
              else begin
                cnt_d[i] = cnt_q[i] - 4'd1;
                c        = 1'b0;
              end
            end
          end
        end
        tick_d = 1'b1;
        ovf_d  = c;
      end
    end
  end

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] lz;
`endif
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    enb_d        = '1;
    enb_d[idx_q] = 1'b0;
    seg_d        = seg7(cnt_q[idx_q]);
    dp_d         = DP_EN && (idx_q == DP_SEL);
`ifdef LEADING_ZERO_BLANK_EN
    // lz[i]: digit i and every more-significant digit are zero
    lz[DIGITS-1] = (cnt_q[DIGITS-1] == 4'd0);
    for (int unsigned i = 1; i < DIGITS; i++)
      lz[DIGITS-1-i] = (cnt_q[DIGITS-1-i] == 4'd0) && lz[DIGITS-i];
    if ((idx_q != '0) && lz[idx_q]) seg_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
      div_q  <= '0;
      idx_q  <= '0;
      enb_q  <= '1;
      seg_q  <= '0;
      dp_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      ovf_q  <= ovf_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      enb_q  <= enb_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign bus.o_seg_enb = enb_q;
  assign bus.o_seg     = seg_q;
  assign bus.o_seg_dp  = dp_q;
  assign bus.o_tick    = tick_q;
  assign bus.o_ovf     = ovf_q;
endmodule

// File: tb/tb_nco_bcd_scan_disp.sv
// Scoreboard bench for nco_bcd_scan_disp: an integer-valued counter/accumulator model
// queues expected display and tick events; a negedge monitor pops and compares them.
module tb_nco_bcd_scan_disp;
  localparam int D   = 3;
  localparam int NW  = 4;
  localparam int SD  = 4;
  localparam int DP  = 1;
  localparam int MOD = 1000;
  localparam int ACC_MOD = 16;

  typedef struct {
    int           e;
    logic [D-1:0] enb;
    logic [6:0]   seg;
    logic         dp;
  } disp_t;

  typedef struct {
    int   e;
    logic ovf;
  } tick_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   edge_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   m_acc = 0;
  int   m_cnt = 0;
  disp_t dq[$];
  tick_t tq[$];
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  nco_bcd_scan_disp_if #(.DIGITS(D), .NCO_WIDTH(NW)) bus ();

  nco_bcd_scan_disp #(
    .DIGITS(D), .NCO_WIDTH(NW), .SCAN_DIV(SD), .DP_POS(DP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt = 0;
    else        edge_cnt = edge_cnt + 1;
  end

  function automatic int p10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  // Sets inputs for the next edge, queues what that edge must produce, advances the model.
  task automatic step(input int inc, input bit run, input bit up, input bit clr);
    disp_t de;
    tick_t te;
    int    k;
    int    s;
    bus.i_nco_inc = NW'(inc);
    bus.i_run     = run;
    bus.i_up      = up;
    bus.i_clear   = clr;
    de.e   = edge_cnt + 1;
    k      = ((de.e - 1) / SD) % D;
    de.enb = '1;
    de.enb[k] = 1'b0;
    de.seg = seg_tab[(m_cnt / p10(k)) % 10];
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && m_cnt < p10(k)) de.seg = 7'h00;
`endif
    de.dp = (k == DP);
    dq.push_back(de);
    if (clr) begin
      m_acc = 0;
      m_cnt = 0;
    end else if (run) begin
      s     = m_acc + inc;
      m_acc = s % ACC_MOD;
      if (s >= ACC_MOD) begin
        te.e   = de.e;
        te.ovf = 1'b0;
        if (up) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == MOD) begin m_cnt = 0; te.ovf = 1'b1; end
        end else begin
          if (m_cnt == 0) begin m_cnt = MOD - 1; te.ovf = 1'b1; end
          else m_cnt = m_cnt - 1;
        end
        tq.push_back(te);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_blank(input string name);
    n_tests++;
    if (bus.o_seg_enb !== 3'b111 || bus.o_seg !== 7'h00 || bus.o_seg_dp !== 1'b0 ||
        bus.o_tick !== 1'b0 || bus.o_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: enb=%b seg=%h dp=%b tick=%b ovf=%b, expected enb=111 seg=00 dp=0 tick=0 ovf=0",
               name, bus.o_seg_enb, bus.o_seg, bus.o_seg_dp, bus.o_tick, bus.o_ovf);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      disp_t d;
      tick_t t;
      bit    exp_t;
      if (dq.size() > 0 && dq[0].e == edge_cnt) begin
        d = dq.pop_front();
        n_tests++;
        if (bus.o_seg_enb !== d.enb || bus.o_seg !== d.seg || bus.o_seg_dp !== d.dp) begin
          n_fail++;
          $display("FAIL disp e=%0d: enb=%b seg=%h dp=%b, expected enb=%b seg=%h dp=%b",
                   edge_cnt, bus.o_seg_enb, bus.o_seg, bus.o_seg_dp, d.enb, d.seg, d.dp);
        end
      end
      exp_t = (tq.size() > 0 && tq[0].e == edge_cnt);
      t.ovf = 1'b0;
      if (exp_t) t = tq.pop_front();
      if (exp_t || bus.o_tick !== 1'b0 || bus.o_ovf !== 1'b0) begin
        n_tests++;
        if (bus.o_tick !== exp_t || bus.o_ovf !== t.ovf) begin
          n_fail++;
          $display("FAIL tick e=%0d: tick=%b ovf=%b, expected tick=%b ovf=%b",
                   edge_cnt, bus.o_tick, bus.o_ovf, exp_t, t.ovf);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_nco_inc = '0;
    bus.i_run     = 1'b0;
    bus.i_up      = 1'b1;
    bus.i_clear   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_blank("reset_hold");
    rst_n = 1'b1;

    // Tick rate: inc 4 of 16 -> one tick per 4 clocks, count reaches 10 after 40
    repeat (40) step(4, 1, 1, 0);
    repeat (12) step(4, 0, 1, 0);

    // Zero increment: never ticks
    repeat (20) step(0, 1, 1, 0);

    // Up wrap 999 -> 000
    step(0, 1, 1, 1);
    for (int i = 0; i < 2000 && m_cnt != 998; i++) step(15, 1, 1, 0);
    repeat (30) step(15, 1, 1, 0);
    repeat (12) step(15, 0, 1, 0);

    // Down wrap 000 -> 999, then frozen for 100 clocks
    step(0, 1, 0, 1);
    repeat (2) step(8, 1, 0, 0);
    repeat (100) step(15, 0, 1, 0);

    // Clear coinciding with an accumulator carry
    step(8, 1, 1, 0);
    step(8, 1, 1, 1);
    repeat (12) step(15, 0, 1, 0);

    // Randomized traffic
    repeat (400) step($urandom_range(0, 15), ($urandom_range(0, 9) != 0),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));

    // Asynchronous reset mid-operation
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_blank("reset_async");
    dq.delete();
    tq.delete();
    m_acc = 0;
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_blank("reset_held");
    rst_n = 1'b1;
    repeat (200) step($urandom_range(0, 15), ($urandom_range(0, 9) != 0),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));

    @(negedge clk);
    #1;
    n_tests++;
    if (dq.size() != 0 || tq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: disp_left=%0d tick_left=%0d, expected 0 and 0", dq.size(), tq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nco_bcd_scan_disp.md
# nco_bcd_scan_disp

Parametrised successor to the fixed six-digit NCO/counter/display top. A phase-accumulator NCO generates count ticks from a programmable increment. Those ticks drive a DIGITS-wide cascaded BCD up/down counter, which is time-multiplexed onto a common-cathode 7-segment bank. The block sits directly under the board top and drives the segment and digit-enable pins.

## Interface
- DIGITS, 6: number of BCD digits and digit enables; legal range 1..8.
- NCO_WIDTH, 32: width of the phase accumulator and the increment.
- SCAN_DIV, 50000: clocks per digit slot (1 kHz slot rate at 50 MHz); must be ≥2.
- DP_POS, 2: index of the digit whose decimal point is lit; a value ≥ DIGITS means no decimal point is lit.

- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- i_nco_inc  in  NCO_WIDTH  accumulator increment; tick rate = f_clk × i_nco_inc / 2^NCO_WIDTH.
- i_run  in  1  1 = accumulator advances; 0 = accumulator frozen and no ticks.
- i_up  in  1  count direction: 1 = up, 0 = down. Sampled on each tick.
- i_clear  in  1  synchronous clear of the counter and the accumulator.
- o_seg_enb  out  DIGITS  digit enables, active-low, one-hot-low while scanning.
- o_seg_dp  out  1  decimal point, active-high.
- o_seg  out  7  segments, active-high; bit0 = a … bit6 = g.
- o_tick  out  1  one-clock pulse per NCO tick.
- o_ovf  out  1  one-clock pulse on counter wrap.

## Operation
- **NCO**
  - While i_run=1: acc <= acc + i_nco_inc, computed with an NCO_WIDTH+1 bit sum.
  - A carry out of the MSB is a tick.
  - i_nco_inc = 0 produces no ticks.
- **Counter**: DIGITS BCD digits, digit 0 is the least significant.
  - Up count: increment with decimal carry; every digit at 9 wraps to all 0 and pulses o_ovf.
  - Down count: decrement with decimal borrow; all 0 wraps to every digit at 9 and pulses o_ovf.
  - Digit values never leave 0..9.
- **Clear priority**: i_clear > tick. On i_clear the counter and acc go to 0, and neither o_tick nor o_ovf pulses that cycle, even if a carry would have occurred.
- **Run**: i_run=0 holds acc and the counter.
- **Scan**
  - A divider counts 0..SCAN_DIV-1.
  - At its terminal count, the digit index advances 0→1→…→DIGITS-1→0.
  - The selected digit's enable bit is 0; all other enable bits are 1.
  - o_seg is the hex-to-7-segment decode of the selected digit (0..9 only).
  - o_seg_dp = 1 when the index equals DP_POS.
- **State**: the NCO, counter and scan paths are all free-running registers. There is no handshake.

## Timing
- **Reset values**
  - acc = 0, counter = 0, scan divider = 0, index = 0.
  - o_seg_enb = all 1s (blank), o_seg = 0, o_seg_dp = 0, o_tick = 0, o_ovf = 0.
- **Tick path**
  - The accumulator carry is evaluated combinationally.
  - On the same rising edge: acc updates, the counter updates, o_tick <= 1, and o_ovf <= wrap.
  - o_tick and o_ovf are therefore high in the first cycle in which the new count is visible.
- **Display path**
  - o_seg, o_seg_dp and o_seg_enb are registered.
  - They reflect the index and counter value one clock after those change.
  - The first edge after reset release drives digit 0 (enable bit 0 low).
- **Scan slots**: each digit is enabled for exactly SCAN_DIV clocks. The full frame is DIGITS × SCAN_DIV clocks.
- **Direction**: changing i_up between ticks affects only the next tick; there is no glitch pulse.
- **Reset mid-operation**: all registers return to their reset values immediately (asynchronous reset). Outputs stay blank until the first edge after rst_n goes high.

## Configuration
- **LEADING_ZERO_BLANK_EN**
  - **Defined**: a digit is blanked (o_seg = 0; enable still scans normally) when it and every more-significant digit are 0. Digit 0 is never blanked. o_seg_dp is unaffected.
  - **Undefined**: all digits always display, zeros included.

## Test plan
- **Reset**: DIGITS=2, SCAN_DIV=4, NCO_WIDTH=4. Hold rst_n=0 → o_seg_enb=2'b11, o_seg=0, o_tick=0. Release rst_n → one clock later o_seg_enb=2'b10 and o_seg=7'h3F ('0').
- **Tick rate**: NCO_WIDTH=4, i_nco_inc=4, i_run=1 → o_tick pulses every 4 clocks. After 40 clocks the counter reads 10.
- **Up wrap**: DIGITS=2, count up from 98 → 99, then 00 with o_ovf=1 for exactly one clock on the 99→00 tick.
- **Down wrap**: i_up=0 from 01 → 00, then 99 with o_ovf=1. Digit 1 shows 7'h6F ('9').
- **Clear vs tick**: assert i_clear in the same cycle as an accumulator carry → counter=0, o_tick=0, o_ovf=0. Holding i_run=0 freezes the count for 100 clocks.
- **Scan and DP**: DIGITS=3, SCAN_DIV=4, DP_POS=1 → enables cycle 110, 101, 011 with 4 clocks each, and o_seg_dp=1 only during 101. With LEADING_ZERO_BLANK_EN and count 005, digits 1 and 2 give o_seg=0.
